// File: rtl/sim_data_gen_sched.sv
// Purpose : burst scheduler for the simulated data generator on the DDR FIFO write path.
// Latency : start -> gen_en in 2 cycles when FIFO space is available; all outputs registered.
// Backpr. : a burst is triggered only when fifo_free >= BURST_LEN; otherwise waits in WAIT_SPACE.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, stop         run control pulses (start honoured in IDLE only, stop ends after current burst)
//   cfg_burst_num       bursts per run, 0 = continuous; latched on accepted start
//   cfg_gap             idle cycles after each burst; latched on accepted start
//   fifo_free           free entries in the downstream FIFO
//   gen_en / gen_valid  one-cycle enable pulse to the generator / returned valid beats
//   busy, done          not-IDLE indicator / one-cycle completion pulse
//   err_timeout         sticky: generator stalled mid-burst
//   err_spurious        sticky: gen_valid seen while no burst was being collected
//   burst_cnt           bursts completed since the last accepted start (saturating)
module sim_data_gen_sched #(
    parameter int BURST_LEN = 256,
    parameter int FREE_W    = 16,
    parameter int GAP_W     = 16,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_burst_num,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              gen_en,
    input  logic              gen_valid,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_spurious,
    output logic [CNT_W-1:0]  burst_cnt
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [FREE_W-1:0] BURST_FREE = FREE_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN);
    localparam logic [TMO_W-1:0]  TMO_LIM    = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        TRIG,
        COLLECT,
        GAP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cfg_burst_num_q, cfg_burst_num_d;
    logic [GAP_W-1:0]  cfg_gap_q, cfg_gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              stop_pending_q, stop_pending_d;
    logic              gen_en_q, gen_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_spurious_q, err_spurious_d;

    // Scratch values for the COLLECT decision.
    logic              stop_req;
    logic [BEAT_W-1:0] beat_next;
    logic [TMO_W-1:0]  tmo_next;
    logic [CNT_W-1:0]  burst_next;

    always_comb begin
        state_d         = state_q;
        cfg_burst_num_d = cfg_burst_num_q;
        cfg_gap_d       = cfg_gap_q;
        gap_cnt_d       = gap_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        burst_cnt_d     = burst_cnt_q;
        err_timeout_d   = err_timeout_q;
        err_spurious_d  = err_spurious_q;
        gen_en_d        = 1'b0;

        // A stop arriving in the same cycle as a decision is acted on at once.
        stop_req       = stop_pending_q | stop;
        stop_pending_d = stop_pending_q | (stop && (state_q != IDLE));

        beat_next  = beat_cnt_q + 1'b1;
        tmo_next   = tmo_cnt_q + 1'b1;
        burst_next = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_burst_num_d = cfg_burst_num;
                    cfg_gap_d       = cfg_gap;
                    burst_cnt_d     = '0;
                    err_timeout_d   = 1'b0;
                    err_spurious_d  = 1'b0;
                    stop_pending_d  = 1'b0;
                    state_d         = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (stop_req) begin
                    state_d = DONE;
                end else if (fifo_free >= BURST_FREE) begin
                    gen_en_d = 1'b1;
                    state_d  = TRIG;
                end
            end
            TRIG: begin
                beat_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = COLLECT;
            end
            COLLECT: begin
                if (gen_valid) begin
                    beat_cnt_d = beat_next;
                    tmo_cnt_d  = '0;
                    if (beat_next == BEAT_LAST) begin
                        burst_cnt_d = burst_next;
                        if (stop_req || ((cfg_burst_num_q != '0) && (burst_next == cfg_burst_num_q))) begin
                            state_d = DONE;
                        end else if (cfg_gap_q != '0) begin
                            gap_cnt_d = '0;
                            state_d   = GAP;
                        end else begin
                            state_d = WAIT_SPACE;
                        end
                    end
                end else begin
                    tmo_cnt_d = tmo_next;
                    if (tmo_next == TMO_LIM) begin
                        err_timeout_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            GAP: begin
                if (stop_req) begin
                    state_d = DONE;
                end else if (gap_cnt_q == cfg_gap_q - 1'b1) begin
                    state_d = WAIT_SPACE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                stop_pending_d = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Applied after the start clear so a beat coinciding with start is still flagged.
        if (gen_valid && (state_q != COLLECT)) begin
            err_spurious_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cfg_burst_num_q <= '0;
            cfg_gap_q       <= '0;
            gap_cnt_q       <= '0;
            beat_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            burst_cnt_q     <= '0;
            stop_pending_q  <= 1'b0;
            gen_en_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_spurious_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_burst_num_q <= cfg_burst_num_d;
            cfg_gap_q       <= cfg_gap_d;
            gap_cnt_q       <= gap_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            burst_cnt_q     <= burst_cnt_d;
            stop_pending_q  <= stop_pending_d;
            gen_en_q        <= gen_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_timeout_q   <= err_timeout_d;
            err_spurious_q  <= err_spurious_d;
        end
    end

    assign gen_en       = gen_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;
    assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_sim_data_gen_sched.sv
// Purpose : directed self-checking bench for sim_data_gen_sched (BURST_LEN=8, TIMEOUT=64).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : fifo_free is held below and then raised to the burst size to exercise the space check.
module tb_sim_data_gen_sched;

    localparam int BL = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] cfg_burst_num;
    logic [15:0] cfg_gap;
    logic [15:0] fifo_free;
    logic        gen_en;
    logic        gen_valid;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_spurious;
    logic [15:0] burst_cnt;

    int checks   = 0;
    int failures = 0;
    int n;
    int en_seen;

    sim_data_gen_sched #(
        .BURST_LEN (BL),
        .FREE_W    (16),
        .GAP_W     (16),
        .CNT_W     (16),
        .TIMEOUT   (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .cfg_burst_num (cfg_burst_num),
        .cfg_gap       (cfg_gap),
        .fifo_free     (fifo_free),
        .gen_en        (gen_en),
        .gen_valid     (gen_valid),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .err_spurious  (err_spurious),
        .burst_cnt     (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for gen_en; returns the number of cycles waited.
    task automatic wait_en(output int cycles);
        cycles = 0;
        while (!gen_en && cycles < 300) begin
            tick();
            cycles++;
        end
        chk("gen_en_seen", 32'(gen_en), 1);
    endtask

    // Called in the gen_en cycle: moves into COLLECT and returns `beats` valid beats.
    task automatic run_burst(input int beats);
        tick();
        chk("gen_en_one_cycle", 32'(gen_en), 0);
        gen_valid = 1'b1;
        repeat (beats) tick();
        gen_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; gen_valid = 1'b0;
        cfg_burst_num = '0; cfg_gap = '0; fifo_free = 16'd100;

        // Reset state
        tick(); tick();
        chk("rst_gen_en", 32'(gen_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_timeout", 32'(err_timeout), 0);
        chk("rst_err_spurious", 32'(err_spurious), 0);
        chk("rst_burst_cnt", 32'(burst_cnt), 0);
        rst_n = 1'b1;
        tick();

        // 1: three bursts with a gap of 4; config changed after start must be ignored
        cfg_burst_num = 16'd3; cfg_gap = 16'd4; start = 1'b1;
        tick();
        start = 1'b0; cfg_burst_num = 16'd0; cfg_gap = 16'd0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_en_low_ws", 32'(gen_en), 0);
        wait_en(n);
        chk("t1_start_to_en", n, 1);
        run_burst(BL);
        chk("t1_cnt1", 32'(burst_cnt), 1);
        wait_en(n);
        chk("t1_gap1", n, 5);
        run_burst(BL);
        chk("t1_cnt2", 32'(burst_cnt), 2);
        wait_en(n);
        chk("t1_gap2", n, 5);
        run_burst(BL);
        chk("t1_done", 32'(done), 1);
        chk("t1_cnt3", 32'(burst_cnt), 3);
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_busy_low", 32'(busy), 0);

        // 2: insufficient FIFO space holds off the burst
        cfg_burst_num = 16'd1; cfg_gap = 16'd0; fifo_free = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        en_seen = 0;
        repeat (18) begin
            tick();
            if (gen_en) en_seen++;
        end
        chk("t2_no_early_en", en_seen, 0);
        fifo_free = 16'd8;
        tick();
        chk("t2_en_after_space", 32'(gen_en), 1);
        run_burst(BL);
        chk("t2_done", 32'(done), 1);
        chk("t2_cnt", 32'(burst_cnt), 1);
        tick();
        chk("t2_idle", 32'(busy), 0);
        fifo_free = 16'd100;

        // 3: continuous mode, stop during burst 2 lets it finish
        cfg_burst_num = 16'd0; cfg_gap = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(n);
        run_burst(BL);
        chk("t3_cnt1", 32'(burst_cnt), 1);
        wait_en(n);
        chk("t3_no_gap", n, 1);
        tick();
        gen_valid = 1'b1;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (4) tick();
        gen_valid = 1'b0;
        chk("t3_done", 32'(done), 1);
        chk("t3_cnt2", 32'(burst_cnt), 2);
        en_seen = 0;
        repeat (20) begin
            tick();
            if (gen_en) en_seen++;
        end
        chk("t3_no_more_en", en_seen, 0);
        chk("t3_idle", 32'(busy), 0);

        // 4: generator stalls after 5 beats
        cfg_burst_num = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(n);
        run_burst(5);
        n = 0;
        while (!err_timeout && n < 200) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 64);
        chk("t4_done", 32'(done), 1);
        chk("t4_cnt", 32'(burst_cnt), 0);
        tick();
        chk("t4_sticky", 32'(err_timeout), 1);
        chk("t4_idle", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_cleared", 32'(err_timeout), 0);
        wait_en(n);
        run_burst(BL);
        chk("t4_rerun_done", 32'(done), 1);
        tick();

        // 5: reset during COLLECT beat 3, late beats afterwards
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(n);
        tick();
        gen_valid = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_en", 32'(gen_en), 0);
        chk("t5_rst_cnt", 32'(burst_cnt), 0);
        chk("t5_rst_spur", 32'(err_spurious), 0);
        repeat (5) tick();
        gen_valid = 1'b0;
        chk("t5_late_spur", 32'(err_spurious), 1);
        chk("t5_still_idle", 32'(busy), 0);

        // 6: start+stop together in IDLE, start held high through the run
        cfg_burst_num = 16'd2; start = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t6_busy", 32'(busy), 1);
        chk("t6_spur_cleared", 32'(err_spurious), 0);
        wait_en(n);
        chk("t6_start_to_en", n, 1);
        run_burst(BL);
        chk("t6_cnt1", 32'(burst_cnt), 1);
        wait_en(n);
        run_burst(BL);
        start = 1'b0;
        chk("t6_done", 32'(done), 1);
        chk("t6_cnt2", 32'(burst_cnt), 2);
        tick();
        chk("t6_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
